// File: rtl/vector_store_unit.sv
// Purpose: serialise one masked, strided 8-lane vector store into single-byte memory writes.
// Latency: lane i is driven the cycle after accept edge T+i; done/oob pulse after T+8; ready again after T+9.
// Backpressure: st_ready is low from accept until the DONE cycle ends; the requester holds st_valid meanwhile.
`timescale 1ns/1ps
module vector_store_unit #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LANES     = 8,
  parameter int unsigned MEM_DEPTH = 610
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_W-1:0]       st_base,
  input  logic [ADDR_W-1:0]       st_stride,
  input  logic [LANES*DATA_W-1:0] st_data,
  input  logic [LANES-1:0]        st_mask,
  output logic [ADDR_W-1:0]       addr,
  output logic                    wr_enable,
  output logic [DATA_W-1:0]       inData,
  output logic                    done,
  output logic                    oob
);

  localparam int unsigned     CNT_W   = $clog2(LANES + 1);
  // One extra bit so a depth equal to 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]         acc_q, acc_d;
  logic [ADDR_W-1:0]         stride_q, stride_d;
  logic [LANES*DATA_W-1:0]   data_q, data_d;
  logic [LANES-1:0]          mask_q, mask_d;
  logic                      oob_acc_q, oob_acc_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      wr_q, wr_d;
  logic [DATA_W-1:0]         din_q, din_d;
  logic                      done_q, done_d;
  logic                      oob_q, oob_d;
  logic                      rdy_q, rdy_d;

  logic [ADDR_W-1:0]         slot_addr;
  logic [DATA_W-1:0]         slot_dat;
  logic                      slot_msk;
  logic                      slot_inr;

  // Select the lane for the next slot: lane 0 comes straight from the request at accept,
  // later lanes from the captured copy indexed by the lane counter.
  always_comb begin
    slot_addr = acc_q;
    slot_dat  = '0;
    slot_msk  = 1'b0;
    if (state_q == S_IDLE) begin
      slot_addr = st_base;
      slot_dat  = st_data[DATA_W-1:0];
      slot_msk  = st_mask[0];
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          slot_dat = data_q[k*DATA_W +: DATA_W];
          slot_msk = mask_q[k];
        end
      end
    end
  end

  assign slot_inr = ({1'b0, slot_addr} < DEPTH_L);

  // Next-state and registered-output logic of the store sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    stride_d  = stride_q;
    data_d    = data_q;
    mask_d    = mask_q;
    oob_acc_d = oob_acc_q;
    addr_d    = addr_q;
    din_d     = din_q;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    oob_d     = 1'b0;
    rdy_d     = rdy_q;

    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (st_valid && rdy_q) begin
          stride_d  = st_stride;
          data_d    = st_data;
          mask_d    = st_mask;
          addr_d    = slot_addr;
          din_d     = slot_dat;
          wr_d      = slot_msk && slot_inr;
          oob_acc_d = slot_msk && !slot_inr;
          acc_d     = st_base + st_stride;
          cnt_d     = CNT_W'(1);
          rdy_d     = 1'b0;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        rdy_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
          // Last lane slot has been presented; report completion next cycle.
          done_d  = 1'b1;
          oob_d   = oob_acc_q;
          state_d = S_DONE;
        end else begin
          addr_d    = slot_addr;
          din_d     = slot_dat;
          wr_d      = slot_msk && slot_inr;
          oob_acc_d = oob_acc_q || (slot_msk && !slot_inr);
          acc_d     = acc_q + stride_q;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        rdy_d     = 1'b1;
        cnt_d     = '0;
        oob_acc_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any store and drops the write strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      stride_q  <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      oob_acc_q <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      din_q     <= '0;
      done_q    <= 1'b0;
      oob_q     <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      stride_q  <= stride_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      oob_acc_q <= oob_acc_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      din_q     <= din_d;
      done_q    <= done_d;
      oob_q     <= oob_d;
      rdy_q     <= rdy_d;
    end
  end

  assign st_ready  = rdy_q;
  assign addr      = addr_q;
  assign wr_enable = wr_q;
  assign inData    = din_q;
  assign done      = done_q;
  assign oob       = oob_q;

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed bench for vector_store_unit: two instances, one with the 610-byte depth
// and one with a full 2^20 depth for the address-wrap case; a byte array models
// the memory written by the 610-byte instance.
`timescale 1ns/1ps
module tb_vector_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid_a, st_valid_b;
  logic        ready_a, ready_b;
  logic [19:0] st_base, st_stride;
  logic [63:0] st_data;
  logic [7:0]  st_mask;
  logic [19:0] addr_a, addr_b;
  logic        wr_a, wr_b;
  logic [7:0]  din_a, din_b;
  logic        done_a, done_b, oob_a, oob_b;

  vector_store_unit #(.ADDR_W(20), .DATA_W(8), .LANES(8), .MEM_DEPTH(610)) u_dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid_a), .st_ready(ready_a),
    .st_base(st_base), .st_stride(st_stride), .st_data(st_data), .st_mask(st_mask),
    .addr(addr_a), .wr_enable(wr_a), .inData(din_a), .done(done_a), .oob(oob_a)
  );

  vector_store_unit #(.ADDR_W(20), .DATA_W(8), .LANES(8), .MEM_DEPTH(1 << 20)) u_big (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid_b), .st_ready(ready_b),
    .st_base(st_base), .st_stride(st_stride), .st_data(st_data), .st_mask(st_mask),
    .addr(addr_b), .wr_enable(wr_b), .inData(din_b), .done(done_b), .oob(oob_b)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:609];
  always @(posedge clk) if (wr_a && addr_a < 20'd610) mem[addr_a] <= din_a;

  logic        sel;
  logic [19:0] m_addr;
  logic        m_wr, m_done, m_oob, m_rdy;
  logic [7:0]  m_din;
  assign m_addr = sel ? addr_b  : addr_a;
  assign m_wr   = sel ? wr_b    : wr_a;
  assign m_din  = sel ? din_b   : din_a;
  assign m_done = sel ? done_b  : done_a;
  assign m_oob  = sel ? oob_b   : oob_a;
  assign m_rdy  = sel ? ready_b : ready_a;

  int total = 0;
  int bad   = 0;

  logic [19:0] c_addr [0:23];
  logic        c_wr   [0:23];
  logic [7:0]  c_din  [0:23];
  logic        c_done [0:23];
  logic        c_oob  [0:23];
  logic        c_rdy  [0:23];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request and return 1 time unit after the edge that accepts it.
  task automatic start(input logic use_b, input logic [19:0] b, input logic [19:0] s,
                       input logic [63:0] d, input logic [7:0] m);
    int w;
    sel = use_b;
    st_base = b; st_stride = s; st_data = d; st_mask = m;
    st_valid_a = !use_b;
    st_valid_b = use_b;
    w = 0;
    while (m_rdy !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (w >= 30) chk("accept_timeout", 32'(m_rdy), 32'd1);
    @(posedge clk);
    #1;
    st_valid_a = 1'b0;
    st_valid_b = 1'b0;
  endtask

  task automatic capture(input int off, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      c_addr[off+c] = m_addr;
      c_wr[off+c]   = m_wr;
      c_din[off+c]  = m_din;
      c_done[off+c] = m_done;
      c_oob[off+c]  = m_oob;
      c_rdy[off+c]  = m_rdy;
    end
  endtask

  task automatic check_store(input string tag, input int off, input logic [19:0] b,
                             input logic [19:0] s, input logic [63:0] d,
                             input logic [7:0] exp_wr, input logic exp_oob);
    logic [19:0] la;
    for (int i = 0; i < 8; i++) begin
      la = b + s * 20'(i);
      chk($sformatf("%s_addr%0d", tag, i), 32'(c_addr[off+i]), 32'(la));
      chk($sformatf("%s_wr%0d", tag, i), 32'(c_wr[off+i]), 32'(exp_wr[i]));
      chk($sformatf("%s_data%0d", tag, i), 32'(c_din[off+i]), 32'(d[i*8 +: 8]));
      chk($sformatf("%s_done%0d", tag, i), 32'(c_done[off+i]), 32'd0);
      chk($sformatf("%s_rdy%0d", tag, i), 32'(c_rdy[off+i]), 32'd0);
    end
    chk({tag, "_done"}, 32'(c_done[off+8]), 32'd1);
    chk({tag, "_oob"}, 32'(c_oob[off+8]), 32'(exp_oob));
    chk({tag, "_wr_in_done"}, 32'(c_wr[off+8]), 32'd0);
    chk({tag, "_rdy_in_done"}, 32'(c_rdy[off+8]), 32'd0);
    chk({tag, "_rdy_back"}, 32'(c_rdy[off+9]), 32'd1);
    chk({tag, "_done_once"}, 32'(c_done[off+9]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 610; k++) mem[k] = 8'h00;
    sel = 1'b0;
    rst_n = 1'b0;
    st_valid_a = 1'b0; st_valid_b = 1'b0;
    st_base = '0; st_stride = '0; st_data = '0; st_mask = '0;

    // Reset state
    #1;
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_wr", 32'(wr_a), 32'd0);
    chk("rst_data", 32'(din_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_oob", 32'(oob_a), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready_a), 32'd1);

    // 1: basic store
    start(1'b0, 20'h0, 20'd1, 64'h1716151413121110, 8'hFF);
    capture(0, 10);
    check_store("basic", 0, 20'h0, 20'd1, 64'h1716151413121110, 8'hFF, 1'b0);
    chk("basic_mem0", 32'(mem[0]), 32'h10);
    chk("basic_mem3", 32'(mem[3]), 32'h13);
    chk("basic_mem7", 32'(mem[7]), 32'h17);

    // 2: masked lanes, stride 4
    start(1'b0, 20'h100, 20'd4, 64'h8877665544332211, 8'hA5);
    capture(0, 10);
    check_store("mask", 0, 20'h100, 20'd4, 64'h8877665544332211, 8'hA5, 1'b0);
    chk("mask_addr5", 32'(c_addr[5]), 32'h114);
    chk("mask_mem108", 32'(mem[20'h108]), 32'h33);
    chk("mask_mem10c", 32'(mem[20'h10C]), 32'h00);

    // 3: bounds check, then same window with out-of-range lanes masked off
    start(1'b0, 20'd605, 20'd1, 64'hC7C6C5C4C3C2C1C0, 8'hFF);
    capture(0, 10);
    check_store("oob", 0, 20'd605, 20'd1, 64'hC7C6C5C4C3C2C1C0, 8'h1F, 1'b1);
    chk("oob_mem609", 32'(mem[609]), 32'hC4);
    start(1'b0, 20'd605, 20'd1, 64'hD7D6D5D4D3D2D1D0, 8'h1F);
    capture(0, 10);
    check_store("inb", 0, 20'd605, 20'd1, 64'hD7D6D5D4D3D2D1D0, 8'h1F, 1'b0);

    // 4: address wrap on the full-depth instance
    start(1'b1, 20'hFFFFE, 20'd1, 64'hE7E6E5E4E3E2E1E0, 8'hFF);
    capture(0, 10);
    check_store("wrap", 0, 20'hFFFFE, 20'd1, 64'hE7E6E5E4E3E2E1E0, 8'hFF, 1'b0);
    chk("wrap_addr2", 32'(c_addr[2]), 32'h00000);
    chk("wrap_addr7", 32'(c_addr[7]), 32'h00005);
    sel = 1'b0;

    // Stride 0: last enabled lane wins
    start(1'b0, 20'h20, 20'd0, 64'hA7A6A5A4A3A2A1A0, 8'h81);
    capture(0, 10);
    check_store("stride0", 0, 20'h20, 20'd0, 64'hA7A6A5A4A3A2A1A0, 8'h81, 1'b0);
    chk("stride0_mem", 32'(mem[20'h20]), 32'hA7);

    // 5: backpressure; second request held (and inputs changed) during the first store
    start(1'b0, 20'h40, 20'd1, 64'h4746454443424140, 8'hFF);
    st_base = 20'h50; st_stride = 20'd2; st_data = 64'hB7B6B5B4B3B2B1B0; st_mask = 8'h3C;
    st_valid_a = 1'b1;
    capture(0, 10);
    @(posedge clk);
    #1;
    st_valid_a = 1'b0;
    capture(10, 10);
    check_store("bpA", 0, 20'h40, 20'd1, 64'h4746454443424140, 8'hFF, 1'b0);
    check_store("bpB", 10, 20'h50, 20'd2, 64'hB7B6B5B4B3B2B1B0, 8'h3C, 1'b0);
    chk("bp_memA7", 32'(mem[20'h47]), 32'h47);
    chk("bp_memB2", 32'(mem[20'h54]), 32'hB2);
    chk("bp_memB5", 32'(mem[20'h5A]), 32'hB5);
    chk("bp_memB0", 32'(mem[20'h50]), 32'h00);

    // 6: reset during slot 3
    start(1'b0, 20'h60, 20'd1, 64'h6766656463626160, 8'hFF);
    capture(0, 4);
    chk("rstmid_slot3_wr", 32'(c_wr[3]), 32'd1);
    chk("rstmid_slot3_addr", 32'(c_addr[3]), 32'h63);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_wr_drop", 32'(wr_a), 32'd0);
    chk("rstmid_done0", 32'(done_a), 32'd0);
    @(negedge clk);
    chk("rstmid_done1", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_nodone%0d", c), 32'(done_a), 32'd0);
    end
    chk("rstmid_ready", 32'(ready_a), 32'd1);
    chk("rstmid_mem60", 32'(mem[20'h60]), 32'h60);
    chk("rstmid_mem62", 32'(mem[20'h62]), 32'h62);
    chk("rstmid_mem63", 32'(mem[20'h63]), 32'h00);
    start(1'b0, 20'h70, 20'd1, 64'h7776757473727170, 8'hFF);
    capture(0, 10);
    check_store("after_rst", 0, 20'h70, 20'd1, 64'h7776757473727170, 8'hFF, 1'b0);
    chk("after_rst_mem77", 32'(mem[20'h77]), 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
